// File: rtl/iobus_mailbox_pkg.sv
// Shared constants for the IO-bus mailbox: register byte offsets, STATUS/CTRL
// bit positions and the address decoder used by the top level.
package iobus_mailbox_pkg;

    localparam int DATA_W = 32;

    localparam logic [31:0] OFS_DATA   = 32'h0000_0000;
    localparam logic [31:0] OFS_STATUS = 32'h0000_0004;
    localparam logic [31:0] OFS_CTRL   = 32'h0000_0008;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_DONE      = 3;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTRL_OVF_CLR = 0;
    localparam int CTRL_DONE    = 1;
    localparam int CTRL_IRQ_EN  = 2;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_DATA,
        REG_STATUS,
        REG_CTRL
    } reg_sel_e;

    // Works on word addresses so the byte lane bits never take part in the match
    function automatic reg_sel_e decodeReg(input logic [29:0] wordAddr,
                                           input logic [29:0] baseWord);
        logic [29:0] ofs;
        reg_sel_e    sel;
        ofs = wordAddr - baseWord;
        sel = REG_NONE;
        if (ofs == OFS_DATA[31:2])        sel = REG_DATA;
        else if (ofs == OFS_STATUS[31:2]) sel = REG_STATUS;
        else if (ofs == OFS_CTRL[31:2])   sel = REG_CTRL;
        return sel;
    endfunction

endpackage

// File: rtl/iobus_mailbox_if.sv
// Push/pop handshake between the mailbox register block (master) and its FIFO
// storage (slave), including the occupancy the STATUS register reports.
interface iobus_mailbox_if
    import iobus_mailbox_pkg::*;
#(
    parameter int DEPTH = 16
);
    logic                     push;
    logic [DATA_W-1:0]        pushData;
    logic                     pop;
    logic                     valid;
    logic [DATA_W-1:0]        head;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output push, pushData, pop,
        input  valid, head, full, empty, count
    );

    modport slave (
        input  push, pushData, pop,
        output valid, head, full, empty, count
    );
endinterface

// File: rtl/iobus_mailbox_fifo.sv
// Mailbox FIFO storage with extra-MSB read/write pointers so full and empty
// are told apart without a separate occupancy counter.
module mailbox_fifo
    import iobus_mailbox_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    iobus_mailbox_if.slave    fifoIo
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic              doPush;
    logic              doPop;

    assign fifoIo.empty = (wptr_q == rptr_q);
    assign fifoIo.full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign fifoIo.count = wptr_q - rptr_q;
    assign fifoIo.valid = !fifoIo.empty;
    assign fifoIo.head  = fifoIo.empty ? '0 : mem[rptr_q[AW-1:0]];

    // A full FIFO still takes a push when the head leaves in the same cycle
    assign doPop  = fifoIo.pop && !fifoIo.empty;
    assign doPush = fifoIo.push && (!fifoIo.full || doPop);

    always_comb begin
        wptr_d = doPush ? wptr_q + (AW+1)'(1) : wptr_q;
        rptr_d = doPop  ? rptr_q + (AW+1)'(1) : rptr_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (doPush) begin
            mem[wptr_q[AW-1:0]] <= fifoIo.pushData;
        end
    end

endmodule

// File: rtl/iobus_mailbox.sv
// IO-bus mailbox: firmware pushes words through DATA, a host drains them; STATUS
// and CTRL carry sticky done/overflow flags. IOBUS_MAILBOX_IRQ_EN adds o_irq.
module iobus_mailbox
    import iobus_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int          DEPTH     = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_iobus_re,
    input  logic        i_iobus_we,
    input  logic [3:0]  i_iobus_sel,
    input  logic [31:0] i_iobus_addr,
    input  logic [31:0] i_iobus_data,
    output logic [31:0] o_iobus_data,
    output logic        o_host_valid,
    output logic [31:0] o_host_data,
    input  logic        i_host_ready,
    output logic        o_done,
    output logic        o_overflow
`ifdef IOBUS_MAILBOX_IRQ_EN
    ,
    output logic        o_irq
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    iobus_mailbox_if #(.DEPTH(DEPTH)) fifoBus ();

    mailbox_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .fifoIo (fifoBus.slave)
    );

    reg_sel_e    regSel;
    logic        pushReq;
    logic        popReq;
    logic        dropPush;
    logic        ctrlWrite;
    logic [31:0] pushWord;
    logic [31:0] statusWord;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        overflow_q, overflow_d;
    logic        irqEn_q, irqEn_d;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^i_iobus_addr[1:0];
    assign regSel    = decodeReg(i_iobus_addr[31:2], BASE_ADDR[31:2]);
    assign pushReq   = i_iobus_we && (regSel == REG_DATA);
    assign popReq    = fifoBus.valid && i_host_ready;
    assign dropPush  = pushReq && fifoBus.full && !popReq;
    assign ctrlWrite = i_iobus_we && (regSel == REG_CTRL) && i_iobus_sel[0];

    always_comb begin
        pushWord = '0;
        for (int b = 0; b < 4; b++) begin
            pushWord[8*b +: 8] = i_iobus_sel[b] ? i_iobus_data[8*b +: 8] : 8'h00;
        end
    end

    assign fifoBus.push     = pushReq;
    assign fifoBus.pushData = pushWord;
    assign fifoBus.pop      = popReq;

    // A drop in the same cycle as an overflow-clear leaves the flag set
    always_comb begin
        done_d     = done_q;
        overflow_d = overflow_q;
        irqEn_d    = irqEn_q;
        if (ctrlWrite) begin
            done_d  = done_q | i_iobus_data[CTRL_DONE];
            irqEn_d = i_iobus_data[CTRL_IRQ_EN];
            if (i_iobus_data[CTRL_OVF_CLR]) overflow_d = 1'b0;
        end
        if (dropPush) overflow_d = 1'b1;
    end

    always_comb begin
        statusWord                          = '0;
        statusWord[ST_COUNT_LSB +: CW]      = fifoBus.count;
        statusWord[ST_DONE]                 = done_q;
        statusWord[ST_OVERFLOW]             = overflow_q;
        statusWord[ST_FULL]                 = fifoBus.full;
        statusWord[ST_EMPTY]                = fifoBus.empty;
    end

    // Read data comes from pre-edge state, so a same-cycle write is not visible
    always_comb begin
        rdata_d = '0;
        if (i_iobus_re) begin
            case (regSel)
                REG_STATUS: rdata_d = statusWord;
                REG_CTRL:   rdata_d[CTRL_IRQ_EN] = irqEn_q;
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdata_q    <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            irqEn_q    <= 1'b0;
        end else begin
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            irqEn_q    <= irqEn_d;
        end
    end

    assign o_iobus_data = rdata_q;
    assign o_host_valid = fifoBus.valid;
    assign o_host_data  = fifoBus.head;
    assign o_done       = done_q;
    assign o_overflow   = overflow_q;

`ifdef IOBUS_MAILBOX_IRQ_EN
    logic irq_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) irq_q <= 1'b0;
        else       irq_q <= irqEn_q && fifoBus.empty;
    end

    assign o_irq = irq_q;
`endif

endmodule

// File: tb/tb_iobus_mailbox.sv
// Directed and randomized bench for iobus_mailbox, checked every cycle against a
// queue-based model of the mailbox; o_irq is checked when IOBUS_MAILBOX_IRQ_EN is set.
module tb_iobus_mailbox;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        re, we, hostReady;
    logic [3:0]  sel;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, hostData;
    logic        hostValid, done, ovf;
`ifdef IOBUS_MAILBOX_IRQ_EN
    logic        irq;
`endif

    int total;
    int bad;

    logic [31:0] mq[$];
    bit          mOvf, mDone, mIrqEn, mIrq;
    logic [31:0] mRdata;

    always #5 clk = ~clk;

    iobus_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_iobus_re   (re),
        .i_iobus_we   (we),
        .i_iobus_sel  (sel),
        .i_iobus_addr (addr),
        .i_iobus_data (wdata),
        .o_iobus_data (rdata),
        .o_host_valid (hostValid),
        .o_host_data  (hostData),
        .i_host_ready (hostReady),
        .o_done       (done),
        .o_overflow   (ovf)
`ifdef IOBUS_MAILBOX_IRQ_EN
        ,
        .o_irq        (irq)
`endif
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mOvf   = 0;
        mDone  = 0;
        mIrqEn = 0;
        mIrq   = 0;
        mRdata = 0;
    endtask

    // One clock of mailbox behaviour, evaluated from the inputs about to be sampled
    task automatic modelStep();
        logic [31:0] aligned;
        logic [31:0] word;
        logic [31:0] nextRdata;
        bit isData, isStat, isCtrl, pop, full, push, drop;
        aligned   = addr & 32'hFFFF_FFFC;
        isData    = (aligned == BASE);
        isStat    = (aligned == BASE + 32'd4);
        isCtrl    = (aligned == BASE + 32'd8);
        pop       = (mq.size() > 0) && hostReady;
        full      = (mq.size() == DEPTH);
        nextRdata = 0;
        if (re && isStat)
            nextRdata = 32'(mq.size() * 256) + (mDone ? 8 : 0) + (mOvf ? 4 : 0)
                        + (full ? 2 : 0) + (mq.size() == 0 ? 1 : 0);
        if (re && isCtrl)
            nextRdata = mIrqEn ? 32'd4 : 32'd0;
        mIrq = mIrqEn && (mq.size() == 0);
        word = 0;
        for (int b = 0; b < 4; b++)
            if (sel[b]) word[8*b +: 8] = wdata[8*b +: 8];
        push = we && isData;
        drop = push && full && !pop;
        if (pop) void'(mq.pop_front());
        if (push && !drop) mq.push_back(word);
        if (we && isCtrl && sel[0]) begin
            if (wdata[1]) mDone = 1;
            if (wdata[0]) mOvf = 0;
            mIrqEn = wdata[2];
        end
        if (drop) mOvf = 1;
        mRdata = nextRdata;
    endtask

    task automatic checkOutput();
        cmp("host_valid", 32'(hostValid), 32'(mq.size() > 0));
        cmp("host_data", hostData, (mq.size() > 0) ? mq[0] : 32'd0);
        cmp("iobus_rdata", rdata, mRdata);
        cmp("done", 32'(done), 32'(mDone));
        cmp("overflow", 32'(ovf), 32'(mOvf));
`ifdef IOBUS_MAILBOX_IRQ_EN
        cmp("irq", 32'(irq), 32'(mIrq));
`endif
    endtask

    task automatic applyStimulus(input bit r, input bit w, input logic [3:0] s,
                                 input logic [31:0] a, input logic [31:0] d, input bit rdy);
        re        = r;
        we        = w;
        sel       = s;
        addr      = a;
        wdata     = d;
        hostReady = rdy;
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        re = 0; we = 0; sel = 0; addr = 0; wdata = 0; hostReady = 0;
        modelReset();
        repeat (2) @(negedge clk);
        cmp("reset_valid", 32'(hostValid), 32'd0);
        cmp("reset_data", hostData, 32'd0);
        cmp("reset_rdata", rdata, 32'd0);
        cmp("reset_done", 32'(done), 32'd0);
        cmp("reset_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        applyStimulus(0, 1, 4'hF, BASE, 32'hA5A5_A5A5, 0);
        cmp("first_push_valid", 32'(hostValid), 32'd1);
        cmp("first_push_data", hostData, 32'hA5A5_A5A5);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);
        cmp("after_pop_valid", 32'(hostValid), 32'd0);

        applyStimulus(0, 1, 4'b0011, BASE + 32'd2, 32'hFFFF_FFFF, 0);
        cmp("sel_mask_head", hostData, 32'h0000_FFFF);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);

        for (int i = 0; i < 17; i++) applyStimulus(0, 1, 4'hF, BASE, 32'(i + 1), 0);
        cmp("ovf_after_17", 32'(ovf), 32'd1);
        applyStimulus(1, 0, 4'h0, BASE + 32'd4, 32'h0, 0);
        cmp("status_full_ovf", rdata, 32'h0000_1006);
        for (int i = 0; i < 16; i++) begin
            cmp("drain_order", hostData, 32'(i + 1));
            applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);
        end
        cmp("drained_empty", 32'(hostValid), 32'd0);

        applyStimulus(0, 1, 4'h1, BASE + 32'd8, 32'h1, 0);
        cmp("ovf_cleared", 32'(ovf), 32'd0);
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, 4'hF, BASE, 32'(i + 32'h100), 0);
        applyStimulus(0, 1, 4'hF, BASE, 32'h1F, 1);
        cmp("full_push_pop_ovf", 32'(ovf), 32'd0);
        applyStimulus(1, 0, 4'h0, BASE + 32'd4, 32'h0, 0);
        cmp("status_full_no_ovf", rdata, 32'h0000_1002);
        for (int i = 0; i < 15; i++) applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);
        cmp("last_head", hostData, 32'h1F);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);

        applyStimulus(0, 1, 4'h1, BASE + 32'd8, 32'h2, 0);
        cmp("done_set", 32'(done), 32'd1);
        applyStimulus(1, 0, 4'h0, BASE + 32'd4, 32'h0, 0);
        cmp("status_done_bit", 32'(rdata[3]), 32'd1);
        applyStimulus(0, 0, 4'h0, BASE + 32'd4, 32'h0, 0);
        cmp("idle_rdata", rdata, 32'd0);
        applyStimulus(1, 1, 4'h1, BASE + 32'd8, 32'h4, 0);
        cmp("rw_pre_write", rdata, 32'd0);
        applyStimulus(1, 0, 4'h0, BASE + 32'd8, 32'h0, 0);
        cmp("ctrl_readback", rdata, 32'd4);
        applyStimulus(1, 0, 4'h0, BASE + 32'd12, 32'h0, 0);
        cmp("miss_rdata", rdata, 32'd0);

        for (int n = 0; n < 600; n++) begin
            int          k;
            logic [31:0] a;
            k = $urandom_range(0, 9);
            if (k < 5)      a = BASE;
            else if (k < 7) a = BASE + 32'd4;
            else if (k < 8) a = BASE + 32'd8;
            else if (k < 9) a = BASE + 32'd12;
            else            a = $urandom;
            a = a + 32'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 60),
                          4'($urandom), a, $urandom, ($urandom_range(0, 99) < 35));
        end

        applyStimulus(0, 1, 4'h1, BASE + 32'd8, 32'h2, 0);
        applyStimulus(0, 1, 4'hF, BASE, 32'hDEAD_BEEF, 0);
        applyStimulus(1, 1, 4'hF, BASE, 32'h1234_5678, 0);
        re = 0; we = 0; hostReady = 0;
        #2 rst = 1'b1;
        #1;
        modelReset();
        cmp("midrst_valid", 32'(hostValid), 32'd0);
        cmp("midrst_data", hostData, 32'd0);
        cmp("midrst_rdata", rdata, 32'd0);
        cmp("midrst_done", 32'(done), 32'd0);
        cmp("midrst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);

`ifdef IOBUS_MAILBOX_IRQ_EN
        applyStimulus(0, 1, 4'h1, BASE + 32'd8, 32'h4, 0);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0);
        cmp("irq_idle_empty", 32'(irq), 32'd1);
        applyStimulus(0, 1, 4'hF, BASE, 32'h0000_00AA, 0);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0);
        cmp("irq_occupied", 32'(irq), 32'd0);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);
        cmp("irq_pop_cycle", 32'(irq), 32'd0);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0);
        cmp("irq_after_empty", 32'(irq), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
